// File: rtl/uart_rx_deserializer_pkg.sv
// Shared types and helpers for the UART receive front end.
package uart_rx_deserializer_pkg;

   localparam int unsigned UART_DATA_W = 8;

   typedef logic bit_t;
   typedef logic [UART_DATA_W-1:0] fifo_in;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } rx_state_t;

   // Counter width that stays at least one bit wide for a modulus of 1.
   function automatic int unsigned cnt_w(input int unsigned modulus);
      return (modulus > 1) ? $clog2(modulus) : 1;
   endfunction

endpackage

// File: rtl/uart_rx_deserializer_baud_tick.sv
// Oversample tick generator: divides uart_clk by BAUD_DIV, with a synchronous clear
// used to realign the tick phase to a detected start edge.
module uart_baud_tick
   import uart_rx_deserializer_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 27
) (
   input  logic uart_clk_i,
   input  logic reset_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned CntW = cnt_w(BAUD_DIV);
   localparam logic [CntW-1:0] CntMax = CntW'(BAUD_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick_o = (cnt_q == CntMax);
      cnt_d  = cnt_q + 1'b1;
      if (clr_i || tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge uart_clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx_deserializer.sv
// Oversampling 8N1 UART receiver feeding a FIFO write port; flags framing errors and
// overruns as single-cycle pulses.
module uart_rx_deserializer
   import uart_rx_deserializer_pkg::*;
#(
   parameter int unsigned DATA_W     = UART_DATA_W,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned BAUD_DIV   = 27
) (
   input  logic              uart_clk,
   input  logic              reset,
   input  logic              rx,
   input  logic              full,
   output logic              push,
   output logic [DATA_W-1:0] datainput,
   output logic              frame_err,
   output logic              overrun,
   output logic              busy
);

   localparam int unsigned TickW = cnt_w(OVERSAMPLE);
   localparam int unsigned BitW  = cnt_w(DATA_W);
   localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
   localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
   localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_W - 1);

   bit_t rx_meta_q, rx_s_q, rx_prev_q;
   bit_t tick, baud_clr;

   rx_state_t         state_q, state_d;
   logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
   logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [DATA_W-1:0] data_q, data_d;
   bit_t              push_q, push_d;
   bit_t              frame_err_q, frame_err_d;
   bit_t              overrun_q, overrun_d;

   uart_baud_tick #(
      .BAUD_DIV(BAUD_DIV)
   ) u_baud_tick (
      .uart_clk_i(uart_clk),
      .reset_i   (reset),
      .clr_i     (baud_clr),
      .tick_o    (tick)
   );

   always_comb begin
      state_d     = state_q;
      tick_cnt_d  = tick_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      data_d      = data_q;
      push_d      = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      baud_clr    = 1'b0;

      case (state_q)
         IDLE: begin
            if (rx_prev_q && !rx_s_q) begin
               state_d    = START;
               tick_cnt_d = '0;
               baud_clr   = 1'b1;
            end
         end
         START: begin
            if (tick) begin
               if (tick_cnt_q == TickMid) begin
                  // A start bit that is high again at mid-bit was a glitch.
                  if (rx_s_q) begin
                     state_d = IDLE;
                  end else begin
                     state_d    = DATA;
                     tick_cnt_d = '0;
                     bit_cnt_d  = '0;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (tick_cnt_q == TickLast) begin
                  tick_cnt_d              = '0;
                  shreg_d                 = shreg_q >> 1;
                  shreg_d[DATA_W-1]       = rx_s_q;
                  if (bit_cnt_q == BitLast) begin
                     state_d = STOP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (tick_cnt_q == TickLast) begin
                  tick_cnt_d = '0;
                  if (!rx_s_q) begin
                     frame_err_d = 1'b1;
                     state_d     = WAIT_IDLE;
                  end else if (full) begin
                     overrun_d = 1'b1;
                     state_d   = IDLE;
                  end else begin
                     push_d  = 1'b1;
                     data_d  = shreg_q;
                     state_d = IDLE;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         WAIT_IDLE: begin
            if (rx_s_q) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge uart_clk) begin
      if (reset) begin
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         rx_prev_q   <= 1'b1;
         state_q     <= IDLE;
         tick_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         data_q      <= '0;
         push_q      <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         rx_meta_q   <= rx;
         rx_s_q      <= rx_meta_q;
         rx_prev_q   <= rx_s_q;
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         data_q      <= data_d;
         push_q      <= push_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign push      = push_q;
   assign datainput = data_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed and randomized frames against a frame-level outcome model of the receiver.
module tb_uart_rx_deserializer;

   localparam int unsigned BitClk = 32;  // BAUD_DIV=2 x OVERSAMPLE=16

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic       full = 1'b0;
   logic       push, frame_err, overrun, busy;
   logic [7:0] datainput;

   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;

   // Observed events, recorded mid-cycle.
   logic [7:0]  got_q[$];
   int unsigned got_cyc[$];
   int          fe_cnt = 0;
   int          ov_cnt = 0;
   int          viol = 0;
   logic        prev_push = 1'b0, prev_fe = 1'b0, prev_ov = 1'b0;

   // Model expectations.
   logic [7:0]  exp_q[$];
   int          exp_fe = 0;
   int          exp_ov = 0;
   logic [7:0]  last_push = 8'h00;

   uart_rx_deserializer #(
      .DATA_W    (8),
      .OVERSAMPLE(16),
      .BAUD_DIV  (2)
   ) dut (
      .uart_clk (clk),
      .reset    (reset),
      .rx       (rx),
      .full     (full),
      .push     (push),
      .datainput(datainput),
      .frame_err(frame_err),
      .overrun  (overrun),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (push) begin
         got_q.push_back(datainput);
         got_cyc.push_back(cyc);
      end
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (overrun) ov_cnt <= ov_cnt + 1;
      if ((int'(push) + int'(frame_err) + int'(overrun)) > 1) viol <= viol + 1;
      if ((push && prev_push) || (frame_err && prev_fe) || (overrun && prev_ov))
         viol <= viol + 1;
      prev_push <= push;
      prev_fe   <= frame_err;
      prev_ov   <= overrun;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives one 10-bit frame; full takes full_early for the first 8 bit periods and
   // full_stop for the remainder, so only full_stop overlaps the stop-bit sample.
   task automatic drive_frame(input logic [7:0] d, input logic stopb,
                              input logic full_stop, input logic full_early);
      logic [9:0] bits;
      bits = {stopb, d, 1'b0};
      for (int k = 0; k < 10 * BitClk; k++) begin
         rx   = bits[k / BitClk];
         full = (k < 8 * BitClk) ? full_early : full_stop;
         @(posedge clk);
         #1;
      end
      full = 1'b0;
   endtask

   // Frame-level outcome: bad stop -> frame error; good stop -> push or overrun by full.
   task automatic model(input logic [7:0] d, input logic stopb, input logic full_stop);
      if (!stopb) begin
         exp_fe++;
      end else if (full_stop) begin
         exp_ov++;
      end else begin
         exp_q.push_back(d);
         last_push = d;
      end
   endtask

   task automatic send(input logic [7:0] d, input logic stopb,
                       input logic full_stop, input logic full_early);
      model(d, stopb, full_stop);
      drive_frame(d, stopb, full_stop, full_early);
   endtask

   task automatic check_sb(input string tag);
      chk({tag, "_push_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk({tag, "_data"}, {24'h0, got_q[i]}, {24'h0, exp_q[i]});
      chk({tag, "_frame_err_count"}, fe_cnt, exp_fe);
      chk({tag, "_overrun_count"}, ov_cnt, exp_ov);
      got_q.delete();
      got_cyc.delete();
      exp_q.delete();
   endtask

   initial begin
      int unsigned t0, lat, d1, d2;
      logic [7:0]  rd;
      logic        rs, rf, re;
      logic [9:0]  abits;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_push", push, 1'b0);
      chk("rst_datainput", datainput, 8'h00);
      chk("rst_frame_err", frame_err, 1'b0);
      chk("rst_overrun", overrun, 1'b0);
      chk("rst_busy", busy, 1'b0);
      reset = 1'b0;
      idle(40);

      // Single frame 0xA5: push about half a bit after the stop bit starts.
      t0 = cyc;
      send(8'hA5, 1'b1, 1'b0, 1'b0);
      lat = (got_cyc.size() > 0) ? got_cyc[0] - t0 : 0;
      chk("a5_latency_window", (lat >= 9 * BitClk + 8) && (lat <= 10 * BitClk - 4), 1'b1);
      check_sb("a5");
      chk("a5_hold", datainput, 8'hA5);
      chk("a5_busy_after", busy, 1'b0);

      // Back-to-back frames, no idle gap.
      send(8'h00, 1'b1, 1'b0, 1'b0);
      send(8'hFF, 1'b1, 1'b0, 1'b0);
      send(8'h3C, 1'b1, 1'b0, 1'b0);
      d1 = (got_cyc.size() >= 2) ? got_cyc[1] - got_cyc[0] : 0;
      d2 = (got_cyc.size() >= 3) ? got_cyc[2] - got_cyc[1] : 0;
      chk("b2b_spacing_1", d1, 10 * BitClk);
      chk("b2b_spacing_2", d2, 10 * BitClk);
      check_sb("b2b");

      // Bad stop bit followed by a long break.
      send(8'h55, 1'b0, 1'b0, 1'b0);
      rx = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      chk("break_busy", busy, 1'b1);
      check_sb("ferr");
      idle(6);
      chk("break_released_busy", busy, 1'b0);
      send(8'h12, 1'b1, 1'b0, 1'b0);
      check_sb("after_ferr");

      // Overrun: good frame dropped while full, datainput retains last pushed byte.
      send(8'h81, 1'b1, 1'b1, 1'b1);
      check_sb("overrun");
      chk("overrun_hold", datainput, {24'h0, last_push});
      // full high only outside the stop sample does not matter.
      send(8'hC3, 1'b1, 1'b0, 1'b1);
      check_sb("full_early_only");

      // Short low glitch on an idle line.
      rx = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      idle(40);
      check_sb("glitch");
      chk("glitch_busy", busy, 1'b0);

      // Randomized frames separated by one idle bit.
      for (int n = 0; n < 10; n++) begin
         rd = 8'($urandom);
         rs = ($urandom_range(0, 3) != 0);
         rf = ($urandom_range(0, 3) == 0);
         re = 1'($urandom_range(0, 1));
         send(rd, rs, rf, re);
         idle(BitClk);
      end
      check_sb("random");
      chk("random_hold", datainput, {24'h0, last_push});

      // Reset in the middle of data bit 4; remaining line bits are all high.
      rd = 8'hF0 | 8'($urandom_range(0, 15));
      abits = {1'b1, rd, 1'b0};
      for (int k = 0; k < 5 * BitClk + BitClk / 2; k++) begin
         rx = abits[k / BitClk];
         @(posedge clk);
         #1;
      end
      rx = abits[5];
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("midrst_push", push, 1'b0);
      chk("midrst_datainput", datainput, 8'h00);
      chk("midrst_frame_err", frame_err, 1'b0);
      chk("midrst_overrun", overrun, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      for (int k = 5 * BitClk + BitClk / 2 + 1; k < 10 * BitClk; k++) begin
         rx = abits[k / BitClk];
         @(posedge clk);
         #1;
      end
      idle(20);
      check_sb("aborted");
      send(8'h7E, 1'b1, 1'b0, 1'b0);
      check_sb("after_reset");
      chk("after_reset_hold", datainput, 8'h7E);

      chk("pulse_rules", viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
